// File: rtl/shift_sequencer.sv
// Sequencer that drives an external loadable shift register: loads an operand, issues N
// right-shift enables, then captures the register output as the result.
module shift_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amount,
    input  logic             arith,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] load_val,
    output logic             load_n,
    output logic             shift_right,
    output logic             asr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StCapture} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             arith_q, arith_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            data_q   <= '0;
            cnt_q    <= '0;
            arith_q  <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            arith_q  <= arith_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        arith_d  = arith_q;
        result_d = result_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    data_d  = data_in;
                    cnt_d   = amount;
                    arith_d = arith;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_q != '0) begin
                    state_d = StShift;
                end else begin
                    state_d = StCapture;
                end
            end
            StShift: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    // Counter holds the shifts still to issue, including this cycle's.
                    cnt_d = cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_d = StCapture;
                    end
                end
            end
            StCapture: begin
                state_d = StIdle;
                if (!abort) begin
                    result_d = q_in;
                    done_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Register controls decode from state only, so start/abort never reach them combinationally.
    assign load_val    = data_q;
    assign load_n      = (state_q != StLoad);
    assign shift_right = (state_q == StShift);
    assign asr         = arith_q && (state_q != StIdle);
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign result      = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: models the controlled shift register and scores each
// completion against a queue of expected results.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] data_in = '0;
    logic [2:0] amount = '0;
    logic       arith = 1'b0;
    logic [7:0] q_reg;
    logic [7:0] load_val;
    logic       load_n, shift_right, asr, busy, done;
    logic [7:0] result;

    logic [7:0] exp_q[$];
    logic [7:0] last_res = '0;
    int checks = 0;
    int errors = 0;

    shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .data_in    (data_in),
        .amount     (amount),
        .arith      (arith),
        .q_in       (q_reg),
        .load_val   (load_val),
        .load_n     (load_n),
        .shift_right(shift_right),
        .asr        (asr),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    // External shift register under control of the DUT.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) q_reg <= '0;
        else if (!load_n) q_reg <= load_val;
        else if (shift_right) q_reg <= asr ? {q_reg[7], q_reg[7:1]} : {1'b0, q_reg[7:1]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && done) begin
            if (exp_q.size() == 0) check("spurious_done", done, 0);
            else check("result", result, exp_q.pop_front());
        end
    end

    // now=1 drives start in the current cycle (caller is already at a negedge).
    task automatic run_op(input logic [7:0] d, input logic [2:0] a, input logic ar,
                          input logic [7:0] exp_res, input bit now, input bit poke);
        int n;
        int shifts;
        bit got;
        if (!now) @(negedge clk);
        data_in = d; amount = a; arith = ar; start = 1'b1;
        exp_q.push_back(exp_res);
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; shifts = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            start = poke && (n == 2);
            if (start) begin data_in = 8'hff; amount = 3'd0; end
            if (n == 1) begin
                check("load_n_low", load_n, 0);
                check("load_val", load_val, d);
            end
            if (shift_right) shifts++;
            if (busy) check("asr_busy", asr, ar);
            if (done) got = 1;
        end
        start = 1'b0;
        check("latency", n, a + 3);
        check("shift_count", shifts, a);
        last_res = exp_res;
    endtask

    initial begin
        #2;
        check("rst_load_n", load_n, 1);
        check("rst_shift", shift_right, 0);
        check("rst_asr", asr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_load_val", load_val, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(8'h96, 3'd3, 1'b0, 8'h12, 0, 0);
        check("idle_asr", asr, 0);
        check("idle_load_n", load_n, 1);
        run_op(8'h96, 3'd3, 1'b1, 8'hf2, 0, 0);
        run_op(8'h80, 3'd7, 1'b1, 8'hff, 0, 0);
        run_op(8'h80, 3'd7, 1'b0, 8'h01, 0, 0);
        run_op(8'h5a, 3'd0, 1'b0, 8'h5a, 0, 0);
        run_op(8'h6d, 3'd3, 1'b1, 8'h0d, 0, 1);  // start poked while busy
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            logic [2:0] a;
            logic       ar;
            d  = 8'($urandom);
            a  = 3'($urandom);
            ar = 1'($urandom);
            run_op(d, a, ar, ar ? 8'($signed(d) >>> a) : (d >> a), 0, 0);
        end
        // Back-to-back: second start issued in the done cycle of the first.
        run_op(8'hc3, 3'd1, 1'b1, 8'he1, 1, 0);

        // Abort during the second shift cycle.
        @(negedge clk);
        data_in = 8'h3c; amount = 3'd5; arith = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_shift_active", shift_right, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_result", result, last_res);
        repeat (8) @(negedge clk);
        check("abort_result_held", result, last_res);

        // Abort in IDLE beats a simultaneous start.
        start = 1'b1; abort = 1'b1; data_in = 8'h11; amount = 3'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("idle_abort_busy", busy, 0);

        // Reset mid-shift.
        data_in = 8'hf0; amount = 3'd4; arith = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_shift", shift_right, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_load_n", load_n, 1);
        check("mid_rst_shift", shift_right, 0);
        check("mid_rst_asr", asr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_load_val", load_val, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(8'h96, 3'd2, 1'b0, 8'h25, 1, 0);

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the shift-register data width.
REQ-002 Parameter AMT_W, default 3, SHALL set the shift-amount width; amounts 0..2^AMT_W-1 SHALL be legal.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port start, input, 1: request an operation; sampled only in IDLE.
REQ-006 Port abort, input, 1: synchronous cancel of any operation in progress.
REQ-007 Port data_in, input, WIDTH: operand to load.
REQ-008 Port amount, input, AMT_W: number of right shifts.
REQ-009 Port arith, input, 1: 1 = arithmetic (sign-fill), 0 = logical (zero-fill).
REQ-010 Port q_in, input, WIDTH: current Q of the controlled shift register.
REQ-011 Port load_val, output, WIDTH: parallel load value to the register.
REQ-012 Port load_n, output, 1: active-low load to the register.
REQ-013 Port shift_right, output, 1: shift enable to the register.
REQ-014 Port asr, output, 1: arithmetic-shift select to the register.
REQ-015 Port busy, output, 1: high whenever state is not IDLE.
REQ-016 Port done, output, 1: one-cycle completion pulse.
REQ-017 Port result, output, WIDTH: captured shifted value, held until the next completion.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, SHIFT, CAPTURE; all register-control outputs SHALL be registered or decoded from state only (no combinational path from start/abort).
REQ-019 In IDLE with start=1 and abort=0, the block SHALL latch data_in, amount, arith and go to LOAD; start while not IDLE SHALL be ignored.
REQ-020 LOAD (one cycle): load_n=0, shift_right=0, load_val=latched data; next state SHIFT if latched amount>0, else CAPTURE.
REQ-021 SHIFT: load_n=1, shift_right=1 for exactly latched-amount cycles, tracked by a down-counter; the state SHALL move to CAPTURE after the cycle in which the counter reaches its last shift.
REQ-022 CAPTURE (one cycle): load_n=1, shift_right=0; at the end of this cycle result<=q_in, done<=1; next state IDLE.
REQ-023 done SHALL be high for exactly one cycle, the first IDLE cycle after CAPTURE; a start in that same cycle SHALL be accepted.
REQ-024 Latency from the accepting start edge to the done-high cycle SHALL be amount+3 cycles.
REQ-025 asr SHALL equal the latched arith from LOAD through CAPTURE, and 0 in IDLE.
REQ-026 In IDLE: load_n=1, shift_right=0, busy=0; load_val SHALL hold the last latched data.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE next cycle, with no done and no result update; abort in IDLE SHALL win over a simultaneous start (start ignored).
REQ-028 Counter arithmetic SHALL be AMT_W bits with no wrap: amount = 2^AMT_W-1 SHALL produce exactly that many shifts.

Reset
REQ-029 While reset_n=0: state=IDLE, load_n=1, shift_right=0, asr=0, busy=0, done=0, result=0, load_val=0, counter=0.
REQ-030 Reset asserted mid-operation SHALL abandon it immediately with no done pulse; after release the block SHALL accept a new start on the first edge.

Verification
REQ-031 start, data_in=0x96, amount=3, arith=0 -> 1 LOAD cycle, 3 shift_right cycles, done 6 cycles after start, result=0x12.
REQ-032 start, data_in=0x96, amount=3, arith=1 -> asr=1 throughout, result=0xF2.
REQ-033 start, data_in=0x80, amount=7, arith=1 -> 7 shift cycles, result=0xFF; arith=0 -> result=0x01.
REQ-034 start, amount=0, data_in=0x5A -> no shift_right cycles, done 3 cycles after start, result=0x5A.
REQ-035 abort during 2nd SHIFT cycle -> busy=0 next cycle, no done, result unchanged; start pulsed while busy -> ignored.
REQ-036 reset_n low mid-SHIFT -> all outputs at reset values at once; back-to-back start in the done cycle -> second operation accepted.
